// File: rtl/hdmi_scope_fb.sv
// Double-buffered multi-channel 1-bit scope framebuffer: draws one sample vector per column
// into the back BRAM bank, serves pixel reads from the front bank, swaps banks on frame_start.
module hdmi_scope_fb #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned VAL_RES    = 12,
    parameter int unsigned NUM_CH     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [NUM_CH*VAL_RES-1:0]   s_val,
    input  logic                        frame_start,
    input  logic                        freeze,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [NUM_CH-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        front_sel,
    output logic                        frame_rdy,
    output logic                        b0_we,
    output logic                        b1_we,
    output logic [ADDR_WIDTH-1:0]       b0_addr,
    output logic [ADDR_WIDTH-1:0]       b1_addr,
    output logic [NUM_CH-1:0]           b0_wd,
    output logic [NUM_CH-1:0]           b1_wd,
    input  logic [NUM_CH-1:0]           b0_rd,
    input  logic [NUM_CH-1:0]           b1_rd
);
    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned PW = VAL_RES + $clog2(V_RES + 1);

    typedef enum logic [1:0] {StWait, StDraw, StDone} state_e;

    state_e                      state_q, state_d;
    logic [XW-1:0]               x_q;
    logic [YW-1:0]               y_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [NUM_CH-1:0][YW-1:0]   row_q, prev_q, row_new;
    logic [NUM_CH-1:0][PW-1:0]   prod;
    logic                        front_q, rdy_en_q, rd_valid_q, rd_sel_q;
    logic                        accept, swap, y_last, col_last, draw_we;
    logic [NUM_CH-1:0]           draw_wd;

    assign accept    = s_valid && s_ready;
    assign swap      = (state_q == StDone) && frame_start && !freeze;
    assign y_last    = (y_q == YW'(V_RES - 1));
    assign col_last  = (x_q == XW'(H_RES - 1));
    assign draw_we   = (state_q == StDraw);
    assign front_sel = front_q;

    // Sample to screen row: full-scale maps to the top row, zero to the bottom row.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]    = PW'(s_val[c*VAL_RES +: VAL_RES]) * PW'(V_RES);
            row_new[c] = YW'(V_RES - 1) - YW'(prod[c] >> VAL_RES);
        end
    end

    // Fill the span between the previous and current row so the trace stays connected.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (prev_q[c] <= row_q[c]) begin
                draw_wd[c] = (y_q >= prev_q[c]) && (y_q <= row_q[c]);
            end else begin
                draw_wd[c] = (y_q >= row_q[c]) && (y_q <= prev_q[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:  if (accept) state_d = StDraw;
            StDraw:  if (y_last) state_d = col_last ? StDone : StWait;
            StDone:  if (swap) state_d = StWait;
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            prev_q     <= '0;
            front_q    <= 1'b0;
            rdy_en_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            rdy_en_q   <= 1'b1;
            rd_valid_q <= rd_en;
            rd_sel_q   <= front_q;
            if (accept) begin
                row_q  <= row_new;
                y_q    <= '0;
                addr_q <= ADDR_WIDTH'(x_q);
                if (x_q == '0) begin
                    prev_q <= row_new;
                end
            end
            // Row stride added per cycle instead of multiplying y by H_RES.
            if (draw_we) begin
                y_q    <= y_q + YW'(1);
                addr_q <= addr_q + ADDR_WIDTH'(H_RES);
                if (y_last) begin
                    prev_q <= row_q;
                    x_q    <= col_last ? '0 : x_q + XW'(1);
                end
            end
            if (swap) begin
                front_q <= ~front_q;
                x_q     <= '0;
            end
        end
    end

    always_comb begin
        s_ready   = (state_q == StWait) && rdy_en_q;
        frame_rdy = (state_q == StDone);
        b0_we     = 1'b0;
        b0_addr   = rd_addr;
        b0_wd     = '0;
        b1_we     = 1'b0;
        b1_addr   = rd_addr;
        b1_wd     = '0;
        if (front_q) begin
            b0_we   = draw_we;
            b0_addr = draw_we ? addr_q : '0;
            b0_wd   = draw_we ? draw_wd : '0;
        end else begin
            b1_we   = draw_we;
            b1_addr = draw_we ? addr_q : '0;
            b1_wd   = draw_we ? draw_wd : '0;
        end
        rd_valid = rd_valid_q;
        rd_data  = rd_valid_q ? (rd_sel_q ? b1_rd : b0_rd) : '0;
    end

endmodule

// File: tb/tb_hdmi_scope_fb.sv
// Scoreboard bench for hdmi_scope_fb: expected bank writes and read data are queued when
// stimulus is applied and compared every cycle against the DUT and a pair of BRAM models.
module tb_hdmi_scope_fb;
    localparam int H     = 8;
    localparam int V     = 4;
    localparam int VR    = 4;
    localparam int NC    = 2;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [NC*VR-1:0] s_val;
    logic            frame_start;
    logic            freeze;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [NC-1:0]   rd_data;
    logic            rd_valid;
    logic            front_sel;
    logic            frame_rdy;
    logic            b0_we, b1_we;
    logic [AW-1:0]   b0_addr, b1_addr;
    logic [NC-1:0]   b0_wd, b1_wd;
    logic [NC-1:0]   b0_rd, b1_rd;

    logic [NC-1:0]   mem0 [DEPTH];
    logic [NC-1:0]   mem1 [DEPTH];

    int              checks = 0;
    int              errors = 0;
    bit              front_m, done_m, rdy_m, wait_now, done_now, rd_rand;
    int              x_m, hs_cnt;
    int              prev_m [2];
    logic [7:0]      wq [$];
    logic [1:0]      rq [$];
    logic [1:0]      ref_img [2][DEPTH];

    always #5 clk = ~clk;

    hdmi_scope_fb #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_WIDTH (AW),
        .VAL_RES    (VR),
        .NUM_CH     (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_val       (s_val),
        .frame_start (frame_start),
        .freeze      (freeze),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .front_sel   (front_sel),
        .frame_rdy   (frame_rdy),
        .b0_we       (b0_we),
        .b1_we       (b1_we),
        .b0_addr     (b0_addr),
        .b1_addr     (b1_addr),
        .b0_wd       (b0_wd),
        .b1_wd       (b1_wd),
        .b0_rd       (b0_rd),
        .b1_rd       (b1_rd)
    );

    // External BRAMs: one-cycle read latency, contents cleared while reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            if (b0_we) mem0[b0_addr] <= b0_wd;
            if (b1_we) mem1[b1_addr] <= b1_wd;
        end
        b0_rd <= mem0[b0_addr];
        b1_rd <= mem1[b1_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int row_of(input int v);
        return V - 1 - ((v * V) >> VR);
    endfunction

    task automatic push_col(input int v0, input int v1);
        int r [2];
        int lo, hi;
        logic [1:0] wd;
        r[0] = row_of(v0);
        r[1] = row_of(v1);
        if (x_m == 0) begin
            prev_m[0] = r[0];
            prev_m[1] = r[1];
        end
        for (int y = 0; y < V; y++) begin
            wd = '0;
            for (int c = 0; c < 2; c++) begin
                lo = (prev_m[c] < r[c]) ? prev_m[c] : r[c];
                hi = (prev_m[c] < r[c]) ? r[c] : prev_m[c];
                if (y >= lo && y <= hi) wd[c] = 1'b1;
            end
            wq.push_back(8'(128 + (y * H + x_m) * 4 + int'(wd)));
        end
        prev_m[0] = r[0];
        prev_m[1] = r[1];
        x_m++;
        if (x_m == H) done_m = 1'b1;
    endtask

    // Advance the model by the inputs that the coming clock edge will see.
    task automatic apply_inputs();
        if (!rst) begin
            wq.delete();
            rq.delete();
            front_m   = 1'b0;
            x_m       = 0;
            done_m    = 1'b0;
            rdy_m     = 1'b0;
            prev_m[0] = 0;
            prev_m[1] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                ref_img[0][i] = '0;
                ref_img[1][i] = '0;
            end
            return;
        end
        rdy_m = 1'b1;
        if (rd_en) rq.push_back(ref_img[front_m][rd_addr]);
        if (s_valid && wait_now) begin
            push_col(int'(s_val[3:0]), int'(s_val[7:4]));
            hs_cnt++;
        end
        if (frame_start && !freeze && done_now) begin
            front_m = !front_m;
            x_m     = 0;
            done_m  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic       fw, bw;
        logic [4:0] fa, ba;
        logic [1:0] fwd, bwd;
        logic [7:0] e;
        wait_now = rdy_m && (wq.size() == 0) && !done_m;
        done_now = done_m && (wq.size() == 0);
        check("s_ready", s_ready, wait_now);
        check("frame_rdy", frame_rdy, done_now);
        check("front_sel", front_sel, front_m);
        fw  = front_m ? b1_we : b0_we;
        fa  = front_m ? b1_addr : b0_addr;
        fwd = front_m ? b1_wd : b0_wd;
        bw  = front_m ? b0_we : b1_we;
        ba  = front_m ? b0_addr : b1_addr;
        bwd = front_m ? b0_wd : b1_wd;
        check("front_port", {fw, fa, fwd}, {1'b0, rd_addr, 2'b00});
        if (wq.size() > 0) begin
            e = wq.pop_front();
            check("wr", {bw, ba, bwd}, e);
            ref_img[!front_m][e[6:2]] = e[1:0];
        end else begin
            check("wr_idle", {bw, ba, bwd}, 0);
        end
        if (rq.size() > 0) begin
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, rq.pop_front());
        end else begin
            check("rd_valid_idle", rd_valid, 0);
            check("rd_data_idle", rd_data, 0);
        end
    endtask

    task automatic tick();
        apply_inputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (rd_rand) begin
            rd_en   = 1'b1;
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
        end
    endtask

    task automatic send_col(input int v0, input int v1);
        int n = hs_cnt;
        s_valid = 1'b1;
        s_val   = {4'(v1), 4'(v0)};
        for (int i = 0; i < 40 && hs_cnt == n; i++) tick();
        s_valid = 1'b0;
        check("handshake", 32'(hs_cnt - n), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !done_now; i++) tick();
        check("done_reached", frame_rdy, 1);
    endtask

    task automatic read_const(input int a, input logic [1:0] exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en   = 1'b0;
        rd_addr = '0;
        check("rd_const_valid", rd_valid, 1);
        check("rd_const_data", rd_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        s_valid = 1'b0;
        s_val = '0;
        frame_start = 1'b0;
        freeze = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        rd_rand = 1'b0;
        hs_cnt = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset held for three cycles in the middle of a column
        send_col(15, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("ready_after_release", s_ready, 1);

        // Full frame of constant vectors with s_valid held high
        s_valid = 1'b1;
        s_val   = {4'd0, 4'd15};
        for (int i = 0; i < 100 && !done_m; i++) tick();
        s_valid = 1'b0;
        for (int i = 0; i < 20 && !(done_m && wq.size() == 0); i++) tick();
        // frame_start on the cycle DONE is entered must be ignored
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("entry_no_swap", front_sel, 0);
        tick();

        // Swap in DONE, then read the new front bank
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("swap_front", front_sel, 1);
        read_const(3, 2'b01);
        read_const(24, 2'b10);

        // Second frame into bank 0 with reads every cycle and a stray frame_start mid-draw
        rd_rand = 1'b1;
        rd_en   = 1'b1;
        for (int i = 0; i < H; i++) begin
            send_col((i == 0) ? 0 : 15, 2 * i);
            if (i == 3) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
        end
        wait_done();
        rd_rand = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        tick();

        // Frozen display: frame_start ignored, source back-pressured
        freeze  = 1'b1;
        s_valid = 1'b1;
        repeat (3) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (3) tick();
        end
        check("freeze_front", front_sel, 1);
        s_valid = 1'b0;
        freeze  = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("unfreeze_front", front_sel, 0);

        read_const(1, 2'b01);
        read_const(0, 2'b00);
        read_const(24, 2'b11);
        read_const(9, 2'b01);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
